// File: rtl/fir_tdm_mac.sv
// Time-multiplexed FIR: one MAC walks TAPS coefficients per accepted sample, with a double-buffered coefficient bank.
// Build option: define FIR_SATURATE_EN to clamp the output to DW bits; otherwise the output wraps to DW bits.
module fir_tdm_mac #(
   parameter int TAPS       = 9,
   parameter int DW         = 14,
   parameter int CW         = 32,
   parameter int COEFF_FRAC = 31
) (
   input  logic                     clk,
   input  logic                     rstn,
   input  logic                     ce,
   input  logic signed [DW-1:0]     is_in,
   input  logic                     i_coeff_we,
   input  logic [$clog2(TAPS)-1:0]  i_coeff_addr,
   input  logic signed [CW-1:0]     is_coeff_data,
   input  logic                     i_coeff_commit,
   output logic signed [DW-1:0]     os_out,
   output logic                     o_valid,
   output logic                     o_busy,
   output logic                     o_overrun
);

   localparam int KW = $clog2(TAPS);
   localparam int PW = DW + CW;
   localparam int AW = PW + KW;

   localparam logic [KW:0]            TAPS_K  = (KW+1)'(TAPS);
   localparam logic [KW-1:0]          K_LAST  = KW'(TAPS - 1);
   localparam logic signed [AW-1:0]   HALF    = {{(AW-1){1'b0}}, 1'b1} << (COEFF_FRAC - 1);
   localparam logic signed [AW-1:0]   SAT_MAX = {{(AW-DW+1){1'b0}}, {(DW-1){1'b1}}};
   localparam logic signed [AW-1:0]   SAT_MIN = {{(AW-DW+1){1'b1}}, {(DW-1){1'b0}}};

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_MAC  = 2'd1,
      S_DONE = 2'd2
   } state_e;

   state_e                  state_q, state_d;

   logic signed [DW-1:0]    x_q   [TAPS];
   logic signed [CW-1:0]    shd_q [TAPS];
   logic signed [CW-1:0]    act_q [TAPS];
   logic signed [AW-1:0]    acc_q;
   logic signed [AW-1:0]    acc_d;
   logic [KW-1:0]           k_q;
   logic signed [DW-1:0]    out_q;
   logic                    vld_q;
   logic                    pend_q, pend_d;
   logic                    ovr_q, ovr_d;

   logic                    shift_en;
   logic                    mac_en;
   logic                    done_en;
   logic                    copy_en;
   logic                    wr_ok;

   logic signed [PW-1:0]    prod;
   logic signed [AW-1:0]    prod_ext;
   logic signed [AW-1:0]    res_full;
   logic signed [DW-1:0]    res_dw;

   // Round half up: add one half LSB of the output grid, then drop the fraction.
   function automatic logic signed [AW-1:0] round_half_up(input logic signed [AW-1:0] a);
      return (a + HALF) >>> COEFF_FRAC;
   endfunction

`ifdef FIR_SATURATE_EN
   function automatic logic signed [DW-1:0] saturate_dw(input logic signed [AW-1:0] r);
      if (r > SAT_MAX) begin
         return SAT_MAX[DW-1:0];
      end else if (r < SAT_MIN) begin
         return SAT_MIN[DW-1:0];
      end
      return r[DW-1:0];
   endfunction

   assign res_dw = saturate_dw(res_full);
`else
   logic unused_res_hi;

   // Wrap mode keeps only the low DW bits; the upper bits are intentionally dropped.
   assign res_dw        = res_full[DW-1:0];
   assign unused_res_hi = ^{res_full[AW-1:DW], SAT_MAX[0], SAT_MIN[0]};
`endif

   // ---- single MAC: combinational product straight into the accumulator ----
   assign prod     = PW'(x_q[k_q]) * PW'(act_q[k_q]);
   assign prod_ext = AW'(prod);
   assign acc_d    = acc_q + prod_ext;
   assign res_full = round_half_up(acc_q);

   assign wr_ok    = i_coeff_we && ({1'b0, i_coeff_addr} < TAPS_K);

   // ---- control FSM ----
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q <= S_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      shift_en = 1'b0;
      mac_en   = 1'b0;
      done_en  = 1'b0;
      copy_en  = 1'b0;
      pend_d   = pend_q;
      ovr_d    = ovr_q;
      unique case (state_q)
         S_IDLE: begin
            copy_en = i_coeff_commit;
            if (ce) begin
               shift_en = 1'b1;
               state_d  = S_MAC;
            end
         end
         S_MAC: begin
            mac_en = 1'b1;
            if (ce) begin
               ovr_d = 1'b1;
            end
            if (i_coeff_commit) begin
               pend_d = 1'b1;
            end
            if (k_q == K_LAST) begin
               state_d = S_DONE;
            end
         end
         S_DONE: begin
            done_en = 1'b1;
            copy_en = pend_q || i_coeff_commit;
            pend_d  = 1'b0;
            if (ce) begin
               ovr_d = 1'b1;
            end
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         pend_q <= 1'b0;
         ovr_q  <= 1'b0;
         vld_q  <= 1'b0;
         k_q    <= '0;
      end else begin
         pend_q <= pend_d;
         ovr_q  <= ovr_d;
         vld_q  <= done_en;
         if (shift_en) begin
            k_q <= '0;
         end else if (mac_en) begin
            k_q <= k_q + 1'b1;
         end
      end
   end

   // ---- sample delay line and accumulator ----
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         for (int i = 0; i < TAPS; i++) begin
            x_q[i] <= '0;
         end
         acc_q <= '0;
         out_q <= '0;
      end else begin
         if (shift_en) begin
            x_q[0] <= is_in;
            for (int i = 1; i < TAPS; i++) begin
               x_q[i] <= x_q[i-1];
            end
            acc_q <= '0;
         end else if (mac_en) begin
            acc_q <= acc_d;
         end
         if (done_en) begin
            out_q <= res_dw;
         end
      end
   end

   // ---- coefficient banks: shadow written any time, active loaded on commit ----
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         for (int i = 0; i < TAPS; i++) begin
            shd_q[i] <= '0;
            act_q[i] <= '0;
         end
      end else begin
         if (wr_ok) begin
            shd_q[i_coeff_addr] <= is_coeff_data;
         end
         if (copy_en) begin
            for (int i = 0; i < TAPS; i++) begin
               act_q[i] <= shd_q[i];
            end
         end
      end
   end

   assign os_out    = out_q;
   assign o_valid   = vld_q;
   assign o_busy    = (state_q != S_IDLE);
   assign o_overrun = ovr_q;

endmodule

// File: tb/tb_fir_tdm_mac.sv
// Directed + randomized bench for fir_tdm_mac against an arithmetic reference model of the filter.
module tb_fir_tdm_mac;

   localparam int TAPS       = 9;
   localparam int DW         = 14;
   localparam int CW         = 32;
   localparam int COEFF_FRAC = 31;
`ifdef FIR_SATURATE_EN
   localparam int SAT_FINAL  = 8191;
`else
   localparam int SAT_FINAL  = 8183;
`endif

   logic                   clk;
   logic                   rstn;
   logic                   ce;
   logic signed [DW-1:0]   is_in;
   logic                   i_coeff_we;
   logic [3:0]             i_coeff_addr;
   logic signed [CW-1:0]   is_coeff_data;
   logic                   i_coeff_commit;
   logic signed [DW-1:0]   os_out;
   logic                   o_valid;
   logic                   o_busy;
   logic                   o_overrun;

   int checks;
   int failures;

   int hist [TAPS];
   int sh   [TAPS];
   int act  [TAPS];

   logic signed [DW-1:0] got;
   logic signed [DW-1:0] e1;
   logic signed [DW-1:0] vout;
   int nvalid;
   int vn;
   int mode;
   int dc_exp [9];
   int imp_exp [10];

   fir_tdm_mac #(
      .TAPS(TAPS), .DW(DW), .CW(CW), .COEFF_FRAC(COEFF_FRAC)
   ) dut (
      .clk(clk), .rstn(rstn), .ce(ce), .is_in(is_in),
      .i_coeff_we(i_coeff_we), .i_coeff_addr(i_coeff_addr),
      .is_coeff_data(is_coeff_data), .i_coeff_commit(i_coeff_commit),
      .os_out(os_out), .o_valid(o_valid), .o_busy(o_busy), .o_overrun(o_overrun)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   // Reference: y = round_half_up(sum x[n-k]*c[k] / 2^COEFF_FRAC), then narrowed to DW.
   function automatic logic signed [DW-1:0] ref_out();
      longint acc;
      longint r;
      acc = 0;
      for (int k = 0; k < TAPS; k++) acc += longint'(hist[k]) * longint'(act[k]);
      r = (acc + (longint'(1) <<< (COEFF_FRAC - 1))) >>> COEFF_FRAC;
`ifdef FIR_SATURATE_EN
      if (r > (longint'(1) <<< (DW - 1)) - 1) r = (longint'(1) <<< (DW - 1)) - 1;
      else if (r < -(longint'(1) <<< (DW - 1))) r = -(longint'(1) <<< (DW - 1));
`endif
      return r[DW-1:0];
   endfunction

   function automatic void model_push(input int x);
      for (int k = TAPS - 1; k > 0; k--) hist[k] = hist[k-1];
      hist[0] = x;
   endfunction

   function automatic void model_reset();
      for (int k = 0; k < TAPS; k++) begin
         hist[k] = 0;
         sh[k]   = 0;
         act[k]  = 0;
      end
   endfunction

   task automatic do_reset();
      rstn = 1'b0;
      repeat (3) @(negedge clk);
      rstn = 1'b1;
      model_reset();
   endtask

   task automatic wr(input int addr, input int val);
      i_coeff_we    = 1'b1;
      i_coeff_addr  = 4'(addr);
      is_coeff_data = val;
      @(negedge clk);
      i_coeff_we    = 1'b0;
      if (addr < TAPS) sh[addr] = val;
   endtask

   task automatic commit_idle();
      i_coeff_commit = 1'b1;
      @(negedge clk);
      i_coeff_commit = 1'b0;
      for (int k = 0; k < TAPS; k++) act[k] = sh[k];
   endtask

   // Issues one sample from IDLE and waits for its result; commit_at >= 0 pulses commit mid-operation.
   task automatic sample(input int x, input bit commit_with_ce, input int commit_at,
                         output logic signed [DW-1:0] res);
      logic signed [DW-1:0] expv;
      int  n;
      bit  seen;
      ce             = 1'b1;
      is_in          = DW'(x);
      i_coeff_commit = commit_with_ce;
      if (commit_with_ce) for (int k = 0; k < TAPS; k++) act[k] = sh[k];
      model_push(int'(DW'(x)) <<< (32 - DW) >>> (32 - DW));
      expv = ref_out();
      @(negedge clk);
      ce             = 1'b0;
      i_coeff_commit = 1'b0;
      is_in          = DW'($urandom());
      chk("busy_after_ce", o_busy, 1);
      chk("valid_single_pulse", o_valid, 0);
      n    = 0;
      seen = 0;
      while (!seen && n < 3 * TAPS) begin
         i_coeff_commit = (n == commit_at);
         @(negedge clk);
         n++;
         if (o_valid) seen = 1;
      end
      i_coeff_commit = 1'b0;
      chk("valid_seen", seen, 1);
      chk("latency", n, TAPS + 1);
      chk("out_vs_model", os_out, expv);
      chk("idle_at_valid", o_busy, 0);
      if (commit_at >= 0) for (int k = 0; k < TAPS; k++) act[k] = sh[k];
      res = os_out;
   endtask

   initial begin
      checks         = 0;
      failures       = 0;
      rstn           = 1'b0;
      ce             = 1'b0;
      is_in          = '0;
      i_coeff_we     = 1'b0;
      i_coeff_addr   = '0;
      is_coeff_data  = '0;
      i_coeff_commit = 1'b0;
      dc_exp  = '{333, 667, 1000, 1333, 1667, 2000, 2333, 2667, 3000};
      imp_exp = '{0, 100, 200, 300, 400, 500, 600, 700, 800, 0};

      // Reset state
      do_reset();
      chk("rst_out", os_out, 0);
      chk("rst_valid", o_valid, 0);
      chk("rst_busy", o_busy, 0);
      chk("rst_overrun", o_overrun, 0);

      // DC response, ce at minimum spacing
      for (int k = 0; k < TAPS; k++) wr(k, 238609294);
      commit_idle();
      for (int n = 0; n < 12; n++) begin
         sample(3000, 1'b0, -1, got);
         chk("dc_table", got, (n < 9) ? dc_exp[n] : 3000);
      end

      // Impulse response
      do_reset();
      for (int k = 0; k < TAPS; k++) wr(k, k * (1 << 27));
      commit_idle();
      for (int n = 0; n < 10; n++) begin
         sample((n == 0) ? 1600 : 0, 1'b0, -1, got);
         chk("impulse_table", got, imp_exp[n]);
      end

      // Saturation / wrap
      for (int k = 0; k < TAPS; k++) wr(k, 32'h7fff_ffff);
      commit_idle();
      for (int n = 0; n < TAPS; n++) sample(8191, 1'b0, -1, got);
      chk("sat_final", got, SAT_FINAL);

      // Overrun: second ce lands at edge 5 and must be dropped
      ce    = 1'b1;
      is_in = DW'(1234);
      model_push(1234);
      e1 = ref_out();
      @(negedge clk);
      ce     = 1'b0;
      nvalid = 0;
      vn     = -1;
      vout   = '0;
      for (int n = 1; n <= 2 * TAPS + 4; n++) begin
         if (n == 5) begin
            chk("ovr_before", o_overrun, 0);
            ce    = 1'b1;
            is_in = DW'(-4000);
         end
         @(negedge clk);
         ce = 1'b0;
         if (n == 5) chk("ovr_set", o_overrun, 1);
         if (o_valid) begin
            nvalid++;
            if (vn < 0) begin
               vn   = n;
               vout = os_out;
            end
         end
      end
      chk("ovr_valid_count", nvalid, 1);
      chk("ovr_latency", vn, TAPS + 1);
      chk("ovr_out", vout, e1);
      sample(-2500, 1'b0, -1, got);
      chk("ovr_sticky", o_overrun, 1);
      do_reset();
      chk("ovr_cleared", o_overrun, 0);

      // Commit while busy, out-of-range shadow writes, commit together with ce
      for (int k = 0; k < TAPS; k++) wr(k, 238609294);
      commit_idle();
      sample(3000, 1'b0, -1, got);
      chk("dc_first", got, 333);
      for (int k = 0; k < TAPS; k++) wr(k, int'($urandom_range(0, 32'h3fff_ffff)) - 32'sh2000_0000);
      for (int a = TAPS; a < 16; a++) wr(a, 32'h7fff_ffff);
      sample(-1500, 1'b0, 4, got);
      sample(2222, 1'b0, -1, got);
      sample(-8192, 1'b0, -1, got);
      for (int k = 0; k < TAPS; k++) wr(k, int'($urandom()));
      sample(777, 1'b1, -1, got);
      sample(-777, 1'b0, -1, got);

      // Randomized coefficients, samples and commit timing
      for (int r = 0; r < 4; r++) begin
         for (int k = 0; k < TAPS; k++) wr(k, int'($urandom()));
         wr($urandom_range(TAPS, 15), int'($urandom()));
         mode = $urandom_range(0, 2);
         if (mode == 0) commit_idle();
         for (int s = 0; s < 8; s++) begin
            sample(int'($urandom_range(0, 16383)) - 8192, (mode == 1) && (s == 0),
                   ((mode == 2) && (s == 0)) ? $urandom_range(0, TAPS - 1) : -1, got);
         end
      end

      // Reset in the middle of the MAC
      for (int k = 0; k < TAPS; k++) wr(k, 238609294);
      commit_idle();
      for (int n = 0; n < TAPS; n++) sample(3000, 1'b0, -1, got);
      ce    = 1'b1;
      is_in = DW'(3000);
      @(negedge clk);
      ce = 1'b0;
      repeat (3) @(negedge clk);
      #2 rstn = 1'b0;
      #1;
      chk("midrst_out", os_out, 0);
      chk("midrst_valid", o_valid, 0);
      chk("midrst_busy", o_busy, 0);
      nvalid = 0;
      repeat (TAPS + 3) begin
         @(negedge clk);
         if (o_valid) nvalid++;
      end
      rstn = 1'b1;
      model_reset();
      chk("midrst_no_valid", nvalid, 0);
      for (int k = 0; k < TAPS; k++) wr(k, 238609294);
      commit_idle();
      sample(3000, 1'b0, -1, got);
      chk("midrst_dc_first", got, 333);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
